// File: rtl/pkt_buf_pkg.sv
// Shared defaults, write-FSM states and the stored entry layout for the ingress buffer.
// Pure declarations, no logic.
package pkt_buf_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } wr_state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;

endpackage

// File: rtl/pkt_buf_mem.sv
// Entry storage: one synchronous write port and one combinational read port, no reset.
// Write lands on the clock edge; read has zero latency and never stalls.
module pkt_buf_mem
   import pkt_buf_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_addr,
   input  logic [DATA_W:0] i_wr_dat,
   input  logic [AW-1:0]   i_rd_addr,
   output logic [DATA_W:0] o_rd_dat
);

   logic [DATA_W:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
   end

   assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/pkt_ingress_buffer.sv
// Store-and-forward packet buffer; a packet shows at the output the cycle after its last byte.
// Never backpressures upstream: packets that do not fit are dropped whole and counted.
module pkt_ingress_buffer
   import pkt_buf_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int AW     = $clog2(DEPTH),
   localparam int PW     = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [PW-1:0]     pkt_count,
   output logic [7:0]        drop_cnt
);

   wr_state_t       r_state;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_commit_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_pkt_count;
   logic [7:0]      r_drop_cnt;

   logic            w_in_acc;
   logic            w_full;
   logic            w_wr_en;
   logic            w_commit;
   logic            w_rd_acc;
   logic            w_rd_last;
   logic [DATA_W:0] w_rd_dat;

   // Ready follows reset directly so the very first edge after release can accept a byte.
   assign in_ready  = reset;
   assign w_in_acc  = in_valid && in_ready;
   assign w_full    = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
   assign w_wr_en   = w_in_acc && (r_state != ST_DROP) && !w_full;
   assign w_commit  = w_wr_en && in_last;

   assign out_valid = (r_rd_ptr != r_commit_ptr);
   assign w_rd_acc  = out_valid && out_ready;
   assign {out_last, out_data} = w_rd_dat;
   assign w_rd_last = w_rd_acc && out_last;

   assign pkt_count = r_pkt_count;
   assign drop_cnt  = r_drop_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_rd_ptr     <= '0;
         r_drop_cnt   <= '0;
      end else begin
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
         case (r_state)
            ST_IDLE, ST_RECV: begin
               if (w_in_acc) begin
                  if (w_full) begin
                     // Overflow: forget the partial packet and swallow the rest of it.
                     r_wr_ptr <= r_commit_ptr;
                     if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
                     r_state  <= in_last ? ST_IDLE : ST_DROP;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + PW'(1);
                     if (in_last) begin
                        r_commit_ptr <= r_wr_ptr + PW'(1);
                        r_state      <= ST_IDLE;
                     end else begin
                        r_state      <= ST_RECV;
                     end
                  end
               end
            end
            ST_DROP: begin
               if (w_in_acc && in_last) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pkt_count <= '0;
      end else begin
         case ({w_commit, w_rd_last})
            2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
            2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end

   pkt_buf_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_dat  ({in_last, in_data}),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_dat  (w_rd_dat)
   );

endmodule

// File: tb/tb_pkt_ingress_buffer.sv
// Bench for pkt_ingress_buffer: directed scenarios plus random traffic against a queue-level model.
// The model tracks committed bytes, the partial packet and occupancy, not pointers.
module tb_pkt_ingress_buffer;
   import pkt_buf_pkg::*;

   localparam int DATA_W = DATA_W_DEF;
   localparam int DEPTH  = DEPTH_DEF;
   localparam int PW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [PW-1:0]     pkt_count;
   logic [7:0]        drop_cnt;

   always #5 clk = ~clk;

   pkt_ingress_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .pkt_count (pkt_count),
      .drop_cnt  (drop_cnt)
   );

   int     n_tests = 0;
   int     n_fail  = 0;

   entry_t m_out_q[$];
   entry_t m_part_q[$];
   bit     m_drop;
   int     m_pkts;
   int     m_drops;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit rdy_of(input int mode);
      if (mode == 2) return 1'($urandom_range(0, 1));
      return (mode != 0);
   endfunction

   task automatic model_reset();
      m_out_q.delete();
      m_part_q.delete();
      m_drop  = 1'b0;
      m_pkts  = 0;
      m_drops = 0;
   endtask

   // One clock: drive, check the model's view of the present state, advance the model, clock.
   task automatic step(input bit v, input logic [7:0] d, input bit l, input bit ordy);
      entry_t e;
      int     occ;
      bit     pop;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_out_q.size() != 0));
      if (m_out_q.size() != 0) begin
         chk("out_data", 32'(out_data), 32'(m_out_q[0].data));
         chk("out_last", 32'(out_last), 32'(m_out_q[0].last));
      end
      chk("pkt_count", 32'(pkt_count), 32'(m_pkts));
      chk("drop_cnt", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
      chk("in_ready", 32'(in_ready), 32'd1);

      occ = m_out_q.size() + m_part_q.size();
      pop = ordy && (m_out_q.size() != 0);
      if (pop) begin
         e = m_out_q.pop_front();
         if (e.last) m_pkts--;
      end
      if (v) begin
         if (m_drop) begin
            if (l) m_drop = 1'b0;
         end else if (occ == DEPTH) begin
            m_drops++;
            m_part_q.delete();
            m_drop = !l;
         end else begin
            e.last = l;
            e.data = d;
            m_part_q.push_back(e);
            if (l) begin
               foreach (m_part_q[i]) m_out_q.push_back(m_part_q[i]);
               m_part_q.delete();
               m_pkts++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int len, input logic [7:0] base, input int rmode);
      for (int i = 0; i < len; i++) step(1'b1, base + 8'(i), (i == len - 1), rdy_of(rmode));
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy_of(rmode));
   endtask

   // Holds reset low for half a clock period, between edges, and checks the asynchronous clear.
   task automatic reset_dut();
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      #2;
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      model_reset();
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      reset_dut();

      // Single-byte packet straight through.
      step(1'b1, 8'hA5, 1'b1, 1'b1);
      chk("a5_vld", 32'(out_valid), 32'd1);
      chk("a5_dat", 32'(out_data), 32'hA5);
      chk("a5_last", 32'(out_last), 32'd1);
      chk("a5_cnt", 32'(pkt_count), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("a5_cnt0", 32'(pkt_count), 32'd0);

      // Five-byte packet stays hidden until its last byte is written.
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b1);
         chk("s5_hidden", 32'(out_valid), 32'd0);
      end
      step(1'b1, 8'h05, 1'b1, 1'b1);
      chk("s5_vld", 32'(out_valid), 32'd1);
      chk("s5_first", 32'(out_data), 32'h01);
      idle(8, 1);

      // Fifteen bytes held, next 2-byte packet overflows on its last byte.
      reset_dut();
      send_pkt(5, 8'h10, 0);
      send_pkt(5, 8'h20, 0);
      send_pkt(5, 8'h30, 0);
      send_pkt(2, 8'hE0, 0);
      idle(1, 0);
      chk("ovf_drop", 32'(drop_cnt), 32'd1);
      chk("ovf_pkts", 32'(pkt_count), 32'd3);
      idle(20, 1);
      chk("ovf_drained", 32'(out_valid), 32'd0);

      // A packet longer than the buffer is always dropped.
      reset_dut();
      send_pkt(20, 8'h40, 1);
      chk("long_vld", 32'(out_valid), 32'd0);
      chk("long_drop", 32'(drop_cnt), 32'd1);
      send_pkt(4, 8'h80, 1);
      idle(6, 1);
      chk("long_cnt", 32'(pkt_count), 32'd0);

      // Reset mid-packet with a committed packet waiting.
      reset_dut();
      send_pkt(2, 8'h50, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      chk("mid_vld_pre", 32'(out_valid), 32'd1);
      reset_dut();
      send_pkt(3, 8'h70, 1);
      idle(5, 1);
      chk("mid_cnt", 32'(pkt_count), 32'd0);

      // Drop counter saturates.
      reset_dut();
      send_pkt(16, 8'h00, 0);
      for (int i = 0; i < 260; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
      chk("drop_sat", 32'(drop_cnt), 32'd255);
      chk("sat_pkts", 32'(pkt_count), 32'd1);

      // Random back-to-back traffic with random output stalls.
      reset_dut();
      for (int p = 0; p < 100; p++) send_pkt(int'($urandom_range(1, 16)), 8'($urandom), 2);
      idle(40, 1);
      chk("rand_drops", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
      chk("rand_empty", 32'(out_valid), 32'd0);
      chk("rand_cnt", 32'(pkt_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
